// File: rtl/iir_pkg.sv
// Shared types and constants for the time-multiplexed IIR section scheduler.
package iir_pkg;

  // Sequencer states: one RD/FB/FF triplet per section, then OUT.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    FB   = 3'd2,
    FF   = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Operation performed by the shared biquad arithmetic stage.
  typedef enum logic {
    OP_FB = 1'b0,
    OP_FF = 1'b1
  } mac_op_t;

  // Coefficient-select codes on the config port.
  localparam logic [2:0] SEL_B0 = 3'd0;
  localparam logic [2:0] SEL_B1 = 3'd1;
  localparam logic [2:0] SEL_B2 = 3'd2;
  localparam logic [2:0] SEL_A1 = 3'd3;
  localparam logic [2:0] SEL_A2 = 3'd4;

  // Coefficients are Q2.14: 16384 represents 1.0.
  localparam int FRAC_BITS = 14;
  localparam int COEF_ONE  = 16384;

  // Saturation test for a value against a signed range of width w.
  // Returns {above_max, below_min}; the caller picks the clamp value.
  function automatic logic [1:0] sat_flags(input logic signed [63:0] x,
                                           input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    sat_flags = {(x > hi), (x < lo)};
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared biquad arithmetic: feedback term is registered into w, the
// feedforward term is a combinational, saturated output consumed by the
// sequencer in the same FF cycle.
module biquad_mac
  import iir_pkg::*;
#(
  parameter int DW   = 17,
  parameter int SW   = 40,
  parameter int FRAC = FRAC_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_en,
  input  mac_op_t              i_op,
  input  logic signed [DW-1:0] i_b0,
  input  logic signed [DW-1:0] i_b1,
  input  logic signed [DW-1:0] i_b2,
  input  logic signed [DW-1:0] i_a1,
  input  logic signed [DW-1:0] i_a2,
  input  logic signed [DW-1:0] i_v,
  input  logic signed [SW-1:0] i_w1,
  input  logic signed [SW-1:0] i_w2,
  output logic signed [SW-1:0] o_w,
  output logic signed [DW-1:0] o_vn
);

  // Accumulator is wide enough that neither sum can wrap.
  localparam int AW = SW + DW + 2;
  localparam logic signed [DW-1:0] VN_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] VN_MIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [SW-1:0] r_w;
  logic signed [AW-1:0] w_b0x, w_b1x, w_b2x, w_a1x, w_a2x;
  logic signed [AW-1:0] w_vx, w_w1x, w_w2x, w_wx;
  logic signed [AW-1:0] w_fbSum, w_ffSum, w_ffShift;
  logic signed [SW-1:0] w_wNew;
  logic signed [63:0]   w_ffShift64;
  logic [1:0]           w_satFlags;

  assign w_b0x = {{(AW-DW){i_b0[DW-1]}}, i_b0};
  assign w_b1x = {{(AW-DW){i_b1[DW-1]}}, i_b1};
  assign w_b2x = {{(AW-DW){i_b2[DW-1]}}, i_b2};
  assign w_a1x = {{(AW-DW){i_a1[DW-1]}}, i_a1};
  assign w_a2x = {{(AW-DW){i_a2[DW-1]}}, i_a2};
  assign w_vx  = {{(AW-DW){i_v[DW-1]}}, i_v};
  assign w_w1x = {{(AW-SW){i_w1[SW-1]}}, i_w1};
  assign w_w2x = {{(AW-SW){i_w2[SW-1]}}, i_w2};
  assign w_wx  = {{(AW-SW){r_w[SW-1]}}, r_w};

  assign w_fbSum = w_a1x * w_w1x + w_a2x * w_w2x;
  assign w_wNew  = SW'(w_vx - (w_fbSum >>> FRAC));

  assign w_ffSum     = w_b0x * w_wx + w_b1x * w_w1x + w_b2x * w_w2x;
  assign w_ffShift   = w_ffSum >>> FRAC;
  assign w_ffShift64 = {{(64-AW){w_ffShift[AW-1]}}, w_ffShift};
  assign w_satFlags  = sat_flags(w_ffShift64, DW);

  assign o_vn = w_satFlags[1] ? VN_MAX :
                w_satFlags[0] ? VN_MIN : w_ffShift[DW-1:0];
  assign o_w  = r_w;

  // Capture the recursive state value w during the feedback step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_w <= '0;
    end else if (i_en && (i_op == OP_FB)) begin
      r_w <= w_wNew;
    end
  end

endmodule

// File: rtl/iir_section_scheduler.sv
// Time-multiplexed biquad cascade: one shared arithmetic stage walks all
// sections of the cascade for each accepted input sample.
module iir_section_scheduler
  import iir_pkg::*;
#(
  parameter int N_SEC = 48,
  parameter int DW    = 17,
  parameter int SW    = 40,
  parameter int FRAC  = FRAC_BITS
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DW-1:0]       x_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DW-1:0]       y_out,
  input  logic                       cfg_we,
  input  logic [$clog2(N_SEC)-1:0]   cfg_sec,
  input  logic [2:0]                 cfg_sel,
  input  logic signed [DW-1:0]       cfg_data,
  output logic                       cfg_err,
  output logic                       busy
);

  localparam int SECW = $clog2(N_SEC);
  localparam logic [SECW-1:0] LAST_SEC = SECW'(N_SEC - 1);

  state_t               r_state;
  logic [SECW-1:0]      r_k;
  logic signed [DW-1:0] r_v;
  logic                 r_inReady, r_outValid, r_busy, r_cfgErr;
  logic signed [DW-1:0] r_yOut;

  logic signed [DW-1:0] r_b0 [N_SEC];
  logic signed [DW-1:0] r_b1 [N_SEC];
  logic signed [DW-1:0] r_b2 [N_SEC];
  logic signed [DW-1:0] r_a1 [N_SEC];
  logic signed [DW-1:0] r_a2 [N_SEC];
  logic signed [SW-1:0] r_w1 [N_SEC];
  logic signed [SW-1:0] r_w2 [N_SEC];

  logic signed [DW-1:0] r_cb0, r_cb1, r_cb2, r_ca1, r_ca2;
  logic signed [SW-1:0] r_cw1, r_cw2;

  logic                 w_cfgOk;
  logic                 w_macEn;
  mac_op_t              w_macOp;
  logic signed [SW-1:0] w_w;
  logic signed [DW-1:0] w_vn;

  assign w_cfgOk = (r_state == IDLE) && (cfg_sel <= SEL_A2) &&
                   ({1'b0, cfg_sec} < (SECW+1)'(N_SEC));
  assign w_macEn = (r_state == FB) || (r_state == FF);
  assign w_macOp = (r_state == FB) ? OP_FB : OP_FF;

  biquad_mac #(
    .DW   (DW),
    .SW   (SW),
    .FRAC (FRAC)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_macEn),
    .i_op    (w_macOp),
    .i_b0    (r_cb0),
    .i_b1    (r_cb1),
    .i_b2    (r_cb2),
    .i_a1    (r_ca1),
    .i_a2    (r_ca2),
    .i_v     (r_v),
    .i_w1    (r_cw1),
    .i_w2    (r_cw2),
    .o_w     (w_w),
    .o_vn    (w_vn)
  );

  // Coefficient bank: writes land only while idle, bad writes pulse cfg_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cfgErr <= 1'b0;
      for (int i = 0; i < N_SEC; i++) begin
        r_b0[i] <= DW'(COEF_ONE);
        r_b1[i] <= '0;
        r_b2[i] <= '0;
        r_a1[i] <= '0;
        r_a2[i] <= '0;
      end
    end else begin
      r_cfgErr <= cfg_we && !w_cfgOk;
      if (cfg_we && w_cfgOk) begin
        case (cfg_sel)
          SEL_B0:  r_b0[cfg_sec] <= cfg_data;
          SEL_B1:  r_b1[cfg_sec] <= cfg_data;
          SEL_B2:  r_b2[cfg_sec] <= cfg_data;
          SEL_A1:  r_a1[cfg_sec] <= cfg_data;
          SEL_A2:  r_a2[cfg_sec] <= cfg_data;
          default: ;
        endcase
      end
    end
  end

  // Section sequencer: owns the per-section delay state and handshakes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_v        <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_yOut     <= '0;
      r_busy     <= 1'b0;
      r_cb0      <= '0;
      r_cb1      <= '0;
      r_cb2      <= '0;
      r_ca1      <= '0;
      r_ca2      <= '0;
      r_cw1      <= '0;
      r_cw2      <= '0;
      for (int i = 0; i < N_SEC; i++) begin
        r_w1[i] <= '0;
        r_w2[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_v       <= x_in;
            r_k       <= '0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= RD;
          end
        end
        RD: begin
          r_cb0   <= r_b0[r_k];
          r_cb1   <= r_b1[r_k];
          r_cb2   <= r_b2[r_k];
          r_ca1   <= r_a1[r_k];
          r_ca2   <= r_a2[r_k];
          r_cw1   <= r_w1[r_k];
          r_cw2   <= r_w2[r_k];
          r_state <= FB;
        end
        FB: begin
          r_state <= FF;
        end
        FF: begin
          r_w2[r_k] <= r_cw1;
          r_w1[r_k] <= w_w;
          r_v       <= w_vn;
          if (r_k == LAST_SEC) begin
            r_state <= OUT;
          end else begin
            r_k     <= r_k + SECW'(1);
            r_state <= RD;
          end
        end
        OUT: begin
          if (!r_outValid) begin
            r_outValid <= 1'b1;
            r_yOut     <= r_v;
          end else if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign y_out     = r_yOut;
  assign cfg_err   = r_cfgErr;
  assign busy      = r_busy;

endmodule
